pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//   Converts single-cycle event pulses (e.g. edge-detector outputs on key presses) into a held level of
//   fixed duration. Drives visible indicators (LED, buzzer enable) in the password design.
//   Enforces a gap period after each hold and flags pulses lost during busy time.
// PARAMETERS
//   HOLD_CYCLES  25_000_000  cycles level_out stays high per accepted pulse (>=1; 0.5 s @ 50 MHz)
//   GAP_CYCLES   2           low cycles forced after a hold before a new pulse is accepted (>=0)
//   CNT_W        $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)  counter width (localparam, derived)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   pulse_in   in   1  event pulse, synchronous to clk; a multi-cycle high counts as one pulse per cycle
//   clr        in   1  synchronous abort: return to idle, clear overrun
//   level_out  out  1  stretched level, registered
//   busy       out  1  high whenever state != IDLE
//   done       out  1  1-cycle pulse on the first cycle after a hold ends
//   overrun    out  1  sticky: a pulse arrived while it could not be accepted
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, cnt=0, level_out=0, busy=0, done=0, overrun=0; applies immediately,
//     mid-hold included; first pulse accepted on the first clk edge with rst_n=1.
//   States: IDLE, HOLD, GAP. All outputs registered.
//   IDLE: pulse_in=1 -> HOLD, cnt<=HOLD_CYCLES-1, level_out<=1 (level rises 1 cycle after pulse).
//   HOLD: cnt decrements each cycle; level_out high for exactly HOLD_CYCLES cycles.
//     cnt==0 -> level_out<=0, done<=1; next=GAP with cnt<=GAP_CYCLES-1, or IDLE if GAP_CYCLES==0.
//   GAP: level_out=0, cnt decrements; cnt==0 -> IDLE. Length exactly GAP_CYCLES cycles.
//   pulse_in in HOLD (incl. cnt==0 cycle) or GAP: ignored, overrun<=1 (see RETRIGGER_EN for HOLD).
//   GAP_CYCLES==0: a pulse on the cycle done is high is accepted (state is IDLE then).
//   clr=1: next state IDLE, level_out<=0, done<=0, overrun<=0, cnt<=0; clr wins over pulse_in same cycle.
//   overrun clears only on clr or reset.
//   Counter never wraps: decrement only while cnt!=0.
// CONFIGURATION
//   RETRIGGER_EN defined: pulse_in in HOLD reloads cnt<=HOLD_CYCLES-1, level_out stays high, no overrun,
//     done deferred to the end of the extended hold. Pulses in GAP still set overrun.
//   RETRIGGER_EN undefined: HOLD pulses are dropped and set overrun (default build).
// STRUCTURE
//   Shared package/include password_defs: state encoding localparams (ST_IDLE=2'd0, ST_HOLD=2'd1,
//     ST_GAP=2'd2), default HOLD/GAP cycle constants for the 50 MHz board clock.
//   One sub-module: hold_counter (loadable down-counter, CNT_W wide, load/dec/zero flag, async rst_n).
//   FSM and output registers live in pulse_stretcher.
// TESTING (HOLD_CYCLES=4, GAP_CYCLES=2 unless stated)
//   1 Single pulse at cycle 10 -> level_out high cycles 11-14, done=1 at 15, busy 11-16, idle at 17.
//   2 Pulse at 10 and 12, no RETRIGGER_EN -> level 11-14 only, overrun=1 from 13 onward.
//   3 RETRIGGER_EN, pulses at 10 and 12 -> level 11-16, done at 17, overrun stays 0.
//   4 Pulse in GAP (cycle 15) -> ignored, overrun=1; pulse at 17 -> new hold 18-21.
//   5 GAP_CYCLES=0, pulses at 10 and 15 -> holds 11-14 and 16-19, overrun=0.
//   6 rst_n low at cycle 12 mid-hold -> all outputs 0 immediately; clr+pulse same cycle -> stays IDLE,
//     overrun cleared.

Source files
------------

// File: rtl/password_defs.sv
// rtl/password_defs.sv - shared state encodings and board timing defaults for the password design
package password_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_GAP  = ST_GAP
  } stretch_state_e;

  // 0.5 s indicator hold on the 50 MHz board clock, two dead cycles afterwards
  localparam int DEF_HOLD_CYCLES = 25_000_000;
  localparam int DEF_GAP_CYCLES  = 2;

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - loadable down-counter with zero flag that never wraps
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load has priority; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches event pulses into fixed-length levels with a trailing gap; optional RETRIGGER_EN
module pulse_stretcher
  import password_defs::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  input  logic clr,
  output logic level_out,
  output logic busy,
  output logic done,
  output logic overrun
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

`ifdef RETRIGGER_EN
  localparam bit RetrigEn = 1'b1;
`else
  localparam bit RetrigEn = 1'b0;
`endif

  stretch_state_e   state_q, state_d;
  logic             level_q, level_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // next state, counter control and registered output values
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    done_d       = 1'b0;
    ovr_d        = ovr_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (clr) begin
      state_d  = S_IDLE;
      level_d  = 1'b0;
      ovr_d    = 1'b0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          level_d = 1'b0;
          if (pulse_in) begin
            state_d      = S_HOLD;
            level_d      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (pulse_in && RetrigEn) begin
            level_d      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
          end else begin
            if (pulse_in) begin
              ovr_d = 1'b1;
            end
            if (cnt_zero) begin
              level_d = 1'b0;
              done_d  = 1'b1;
              if (GAP_CYCLES == 0) begin
                state_d = S_IDLE;
              end else begin
                state_d      = S_GAP;
                cnt_load     = 1'b1;
                cnt_load_val = GAP_LOAD;
              end
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        S_GAP: begin
          level_d = 1'b0;
          if (pulse_in) begin
            ovr_d = 1'b1;
          end
          if (cnt_zero) begin
            state_d = S_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          level_d = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign level_out = level_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed vector bench for pulse_stretcher (HOLD=4, GAP=2 and GAP=0)
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst_n;
  logic pulse_in, clr;
  logic level_out, busy, done, overrun;
  logic pulse0, clr0;
  logic level0, busy0, done0, ovr0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       pulse;
    logic       clr;
    logic [3:0] exp;   // {level_out, busy, done, overrun} in the following cycle
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr(clr),
    .level_out(level_out), .busy(busy), .done(done), .overrun(overrun)
  );

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse0), .clr(clr0),
    .level_out(level0), .busy(busy0), .done(done0), .overrun(ovr0)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {lvl,busy,done,ovr}=%b expected %b", name, act, exp);
  endtask

  task automatic add(input logic p, input logic c, input logic [3:0] e);
    vec_t v;
    v.pulse = p; v.clr = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic p, input logic c);
    pulse_in = p;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pulse_in = 1'b0; clr = 1'b0; pulse0 = 1'b0; clr0 = 1'b0;

    // single pulse: level 4 cycles, done, 2 gap cycles, idle
    add(1,0,4'b1100); add(0,0,4'b1100); add(0,0,4'b1100); add(0,0,4'b1100);
    add(0,0,4'b0110); add(0,0,4'b0100); add(0,0,4'b0000);
`ifdef RETRIGGER_EN
    // second pulse during hold extends the level, no overrun
    add(1,0,4'b1100); add(0,0,4'b1100); add(1,0,4'b1100); add(0,0,4'b1100);
    add(0,0,4'b1100); add(0,0,4'b1100); add(0,0,4'b0110); add(0,0,4'b0100);
    add(0,0,4'b0000);
`else
    // second pulse during hold is dropped and flagged
    add(1,0,4'b1100); add(0,0,4'b1100); add(1,0,4'b1101); add(0,0,4'b1101);
    add(0,0,4'b0111); add(0,0,4'b0101); add(0,0,4'b0001); add(0,1,4'b0000);
`endif
    // pulse during gap flagged, pulse after gap starts new hold, clr+pulse stays idle
    add(1,0,4'b1100); add(0,0,4'b1100); add(0,0,4'b1100); add(0,0,4'b1100);
    add(0,0,4'b0110); add(1,0,4'b0101); add(0,0,4'b0001); add(1,0,4'b1101);
    add(0,0,4'b1101); add(0,0,4'b1101); add(0,0,4'b1101); add(0,0,4'b0111);
    add(0,0,4'b0101); add(1,1,4'b0000); add(0,0,4'b0000);
    // clr aborts a hold
    add(1,0,4'b1100); add(0,1,4'b0000); add(0,0,4'b0000);

    #12;
    check("reset_state", {level_out, busy, done, overrun}, 4'b0000);
    check("reset_state_gap0", {level0, busy0, done0, ovr0}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      step(vecs[i].pulse, vecs[i].clr);
      check($sformatf("vec%0d", i), {level_out, busy, done, overrun}, vecs[i].exp);
    end

    // asynchronous reset mid-hold clears outputs without a clock edge
    step(1, 0);
    step(0, 0);
    check("pre_reset_hold", {level_out, busy, done, overrun}, 4'b1100);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {level_out, busy, done, overrun}, 4'b0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", {level_out, busy, done, overrun}, 4'b0000);
    step(1, 0);
    check("after_reset_accept", {level_out, busy, done, overrun}, 4'b1100);
    step(0, 1);

    // GAP_CYCLES=0: pulse on the done cycle is accepted immediately
    for (int k = 0; k < 12; k++) begin
      logic [3:0] e;
      logic       lv, dn;
      pulse0 = (k == 0 || k == 5);
      @(posedge clk); #1;
      lv = ((k + 1) >= 1 && (k + 1) <= 4) || ((k + 1) >= 6 && (k + 1) <= 9);
      dn = ((k + 1) == 5) || ((k + 1) == 10);
      e  = {lv, lv, dn, 1'b0};
      check($sformatf("gap0_c%0d", k + 1), {level0, busy0, done0, ovr0}, e);
    end
    pulse0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
